// File: rtl/multicycle_main_control_if.sv
// Control bundle between the multicycle main-control FSM and the MIPS datapath.
// The controller uses the master modport; the datapath uses slave.
interface multicycle_main_control_if;
  localparam int unsigned OPW = 6;
  localparam int unsigned STW = 4;

  logic [OPW-1:0] Opcode;
  logic           Zero;
  logic           mem_ready;
  logic           IorD;
  logic           MemRead;
  logic           MemWrite;
  logic           IRWrite;
  logic           RegDst;
  logic           MemtoReg;
  logic           RegWrite;
  logic           ALUSrcA;
  logic [1:0]     ALUSrcB;
  logic [1:0]     AluOp;
  logic [1:0]     PCSource;
  logic           PCEn;
  logic [STW-1:0] state_o;
  logic           instr_done;
  logic           illegal_op;

  modport master (
    input  Opcode, Zero, mem_ready,
    output IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, AluOp, PCSource, PCEn, state_o, instr_done, illegal_op
  );

  modport slave (
    output Opcode, Zero, mem_ready,
    input  IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, AluOp, PCSource, PCEn, state_o, instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_main_control.sv
// Moore main-control FSM for the multicycle MIPS datapath with memory-ready stalls.
// Define MULTICYCLE_MAIN_CONTROL_BNE_EN to add the BNE instruction (state 12).
module multicycle_main_control (
  input  logic                        clk,
  input  logic                        reset,
  multicycle_main_control_if.master   bus
);
  localparam int unsigned OPW = 6;
  localparam int unsigned STW = 4;

  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
`ifdef MULTICYCLE_MAIN_CONTROL_BNE_EN
  localparam logic [OPW-1:0] OP_BNE   = 6'b000101;
`endif

  typedef enum logic [STW-1:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BEQ    = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
`ifdef MULTICYCLE_MAIN_CONTROL_BNE_EN
    BNE    = 4'd12,
`endif
    JUMP   = 4'd11
  } state_t;

  // Moore control word; fetch/branch/memwr bits are qualified by mem_ready/Zero at the output.
  typedef struct packed {
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       fetch;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       pcwrite;
    logic       br_eq;
    logic       br_ne;
    logic       done;
    logic       memwr;
  } ctl_t;

  state_t state_q;
  state_t state_d;
  ctl_t   ctl_q;

  function automatic ctl_t decode_ctl(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.memread = 1'b1; c.fetch = 1'b1; c.alusrcb = 2'b01;
      end
      DECODE: c.alusrcb = 2'b11;
      MEMADR: begin
        c.alusrca = 1'b1; c.alusrcb = 2'b10;
      end
      MEMRD: begin
        c.iord = 1'b1; c.memread = 1'b1;
      end
      MEMWB: begin
        c.memtoreg = 1'b1; c.regwrite = 1'b1; c.done = 1'b1;
      end
      MEMWR: begin
        c.iord = 1'b1; c.memwrite = 1'b1; c.memwr = 1'b1;
      end
      EXEC: begin
        c.alusrca = 1'b1; c.aluop = 2'b10;
      end
      ALUWB: begin
        c.regdst = 1'b1; c.regwrite = 1'b1; c.done = 1'b1;
      end
      BEQ: begin
        c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsource = 2'b01;
        c.br_eq = 1'b1; c.done = 1'b1;
      end
`ifdef MULTICYCLE_MAIN_CONTROL_BNE_EN
      BNE: begin
        c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsource = 2'b01;
        c.br_ne = 1'b1; c.done = 1'b1;
      end
`endif
      ADDIEX: begin
        c.alusrca = 1'b1; c.alusrcb = 2'b10;
      end
      ADDIWB: begin
        c.regwrite = 1'b1; c.done = 1'b1;
      end
      JUMP: begin
        c.pcsource = 2'b10; c.pcwrite = 1'b1; c.done = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic opcode_legal(input logic [OPW-1:0] op);
    logic ok;
    ok = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
         (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
`ifdef MULTICYCLE_MAIN_CONTROL_BNE_EN
    ok = ok || (op == OP_BNE);
`endif
    return ok;
  endfunction

  // Next-state logic; unused encodings fall back to FETCH.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.Opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BEQ;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
`ifdef MULTICYCLE_MAIN_CONTROL_BNE_EN
          OP_BNE:       state_d = BNE;
`endif
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: begin
        if (bus.Opcode == OP_LW)      state_d = MEMRD;
        else if (bus.Opcode == OP_SW) state_d = MEMWR;
        else                          state_d = FETCH;
      end
      MEMRD:  state_d = bus.mem_ready ? MEMWB : MEMRD;
      MEMWB:  state_d = FETCH;
      MEMWR:  state_d = bus.mem_ready ? FETCH : MEMWR;
      EXEC:   state_d = ALUWB;
      ALUWB:  state_d = FETCH;
      ADDIEX: state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // Control word is decoded from the next state so it is registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      ctl_q   <= decode_ctl(FETCH);
    end else begin
      state_q <= state_d;
      ctl_q   <= decode_ctl(state_d);
    end
  end

  assign bus.IorD       = ~reset & ctl_q.iord;
  assign bus.MemRead    = ~reset & ctl_q.memread;
  assign bus.MemWrite   = ~reset & ctl_q.memwrite;
  assign bus.IRWrite    = ~reset & ctl_q.fetch & bus.mem_ready;
  assign bus.RegDst     = ~reset & ctl_q.regdst;
  assign bus.MemtoReg   = ~reset & ctl_q.memtoreg;
  assign bus.RegWrite   = ~reset & ctl_q.regwrite;
  assign bus.ALUSrcA    = ~reset & ctl_q.alusrca;
  assign bus.ALUSrcB    = reset ? 2'b00 : ctl_q.alusrcb;
  assign bus.AluOp      = reset ? 2'b00 : ctl_q.aluop;
  assign bus.PCSource   = reset ? 2'b00 : ctl_q.pcsource;
  assign bus.PCEn       = ~reset & ((ctl_q.fetch & bus.mem_ready) | ctl_q.pcwrite |
                                    (ctl_q.br_eq & bus.Zero) | (ctl_q.br_ne & ~bus.Zero));
  assign bus.instr_done = ~reset & (ctl_q.done | (ctl_q.memwr & bus.mem_ready));
  assign bus.illegal_op = ~reset & (state_q == DECODE) & ~opcode_legal(bus.Opcode);
  assign bus.state_o    = state_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed self-checking bench for multicycle_main_control.
// Covers reset, R-type, stalled lw, sw, beq, addi, j, illegal opcode and 000101.
module tb_multicycle_main_control;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   ncyc;

  multicycle_main_control_if bus ();

  multicycle_main_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ncyc   = 0;
    reset  = 1'b1;
    bus.Opcode    = 6'b000000;
    bus.Zero      = 1'b0;
    bus.mem_ready = 1'b1;

    // Reset
    tick();
    chk("rst_state", 8'(bus.state_o), 8'd0);
    chk("rst_memread", 8'(bus.MemRead), 8'd0);
    chk("rst_pcen", 8'(bus.PCEn), 8'd0);
    chk("rst_irwrite", 8'(bus.IRWrite), 8'd0);
    reset = 1'b0;
    #1;
    chk("fetch_memread", 8'(bus.MemRead), 8'd1);
    chk("fetch_alusrcb", 8'(bus.ALUSrcB), 8'd1);
    chk("fetch_irwrite", 8'(bus.IRWrite), 8'd1);
    chk("fetch_pcen", 8'(bus.PCEn), 8'd1);

    // R-type
    tick();
    chk("r_decode", 8'(bus.state_o), 8'd1);
    chk("r_decode_alusrcb", 8'(bus.ALUSrcB), 8'd3);
    chk("r_decode_illegal", 8'(bus.illegal_op), 8'd0);
    tick();
    chk("r_exec", 8'(bus.state_o), 8'd6);
    chk("r_exec_aluop", 8'(bus.AluOp), 8'd2);
    chk("r_exec_alusrca", 8'(bus.ALUSrcA), 8'd1);
    chk("r_exec_done", 8'(bus.instr_done), 8'd0);
    tick();
    chk("r_aluwb", 8'(bus.state_o), 8'd7);
    chk("r_aluwb_regwrite", 8'(bus.RegWrite), 8'd1);
    chk("r_aluwb_regdst", 8'(bus.RegDst), 8'd1);
    chk("r_aluwb_done", 8'(bus.instr_done), 8'd1);
    tick();
    chk("r_back_fetch", 8'(bus.state_o), 8'd0);
    chk("r_fetch_done", 8'(bus.instr_done), 8'd0);

    // Reset mid-EXEC
    tick();
    tick();
    chk("re_exec", 8'(bus.state_o), 8'd6);
    reset = 1'b1;
    #1;
    chk("re_regwrite", 8'(bus.RegWrite), 8'd0);
    chk("re_aluop", 8'(bus.AluOp), 8'd0);
    chk("re_alusrca", 8'(bus.ALUSrcA), 8'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("re_state", 8'(bus.state_o), 8'd0);

    // lw with 2 fetch stalls and 3 memory stalls
    ncyc = 0;
    bus.Opcode    = 6'b100011;
    bus.mem_ready = 1'b0;
    #1;
    chk("lw_stall_irwrite", 8'(bus.IRWrite), 8'd0);
    chk("lw_stall_pcen", 8'(bus.PCEn), 8'd0);
    tick();
    chk("lw_stall1_state", 8'(bus.state_o), 8'd0);
    tick();
    chk("lw_stall2_state", 8'(bus.state_o), 8'd0);
    bus.mem_ready = 1'b1;
    #1;
    chk("lw_ready_irwrite", 8'(bus.IRWrite), 8'd1);
    tick();
    chk("lw_decode", 8'(bus.state_o), 8'd1);
    tick();
    chk("lw_memadr", 8'(bus.state_o), 8'd2);
    chk("lw_memadr_alusrcb", 8'(bus.ALUSrcB), 8'd2);
    tick();
    bus.mem_ready = 1'b0;
    #1;
    chk("lw_memrd", 8'(bus.state_o), 8'd3);
    chk("lw_memrd_iord", 8'(bus.IorD), 8'd1);
    tick();
    tick();
    tick();
    chk("lw_memrd_held", 8'(bus.state_o), 8'd3);
    bus.mem_ready = 1'b1;
    tick();
    chk("lw_memwb", 8'(bus.state_o), 8'd4);
    chk("lw_memwb_memtoreg", 8'(bus.MemtoReg), 8'd1);
    chk("lw_memwb_regwrite", 8'(bus.RegWrite), 8'd1);
    chk("lw_memwb_done", 8'(bus.instr_done), 8'd1);
    tick();
    chk("lw_back_fetch", 8'(bus.state_o), 8'd0);
    chk("lw_total_cycles", 8'(ncyc), 8'd10);

    // sw with one memory stall
    bus.Opcode = 6'b101011;
    tick();
    tick();
    tick();
    bus.mem_ready = 1'b0;
    #1;
    chk("sw_memwr", 8'(bus.state_o), 8'd5);
    chk("sw_stall_memwrite", 8'(bus.MemWrite), 8'd1);
    chk("sw_stall_done", 8'(bus.instr_done), 8'd0);
    tick();
    chk("sw_memwr_held", 8'(bus.state_o), 8'd5);
    bus.mem_ready = 1'b1;
    #1;
    chk("sw_done", 8'(bus.instr_done), 8'd1);
    chk("sw_regwrite", 8'(bus.RegWrite), 8'd0);
    tick();
    chk("sw_back_fetch", 8'(bus.state_o), 8'd0);

    // beq taken, then not taken
    bus.Opcode = 6'b000100;
    bus.Zero   = 1'b1;
    tick();
    tick();
    chk("beq_state", 8'(bus.state_o), 8'd8);
    chk("beq_taken_pcen", 8'(bus.PCEn), 8'd1);
    chk("beq_pcsource", 8'(bus.PCSource), 8'd1);
    chk("beq_aluop", 8'(bus.AluOp), 8'd1);
    chk("beq_done", 8'(bus.instr_done), 8'd1);
    tick();
    chk("beq_back_fetch", 8'(bus.state_o), 8'd0);
    bus.Zero = 1'b0;
    tick();
    tick();
    chk("beq_nt_state", 8'(bus.state_o), 8'd8);
    chk("beq_nt_pcen", 8'(bus.PCEn), 8'd0);
    tick();
    chk("beq_nt_back_fetch", 8'(bus.state_o), 8'd0);

    // addi
    bus.Opcode = 6'b001000;
    tick();
    tick();
    chk("addi_ex", 8'(bus.state_o), 8'd9);
    chk("addi_ex_alusrcb", 8'(bus.ALUSrcB), 8'd2);
    tick();
    chk("addi_wb", 8'(bus.state_o), 8'd10);
    chk("addi_wb_regwrite", 8'(bus.RegWrite), 8'd1);
    chk("addi_wb_regdst", 8'(bus.RegDst), 8'd0);
    tick();
    chk("addi_back_fetch", 8'(bus.state_o), 8'd0);

    // jump
    bus.Opcode = 6'b000010;
    tick();
    tick();
    chk("j_state", 8'(bus.state_o), 8'd11);
    chk("j_pcsource", 8'(bus.PCSource), 8'd2);
    chk("j_pcen", 8'(bus.PCEn), 8'd1);
    chk("j_done", 8'(bus.instr_done), 8'd1);
    tick();
    chk("j_back_fetch", 8'(bus.state_o), 8'd0);

    // Illegal opcode
    bus.Opcode = 6'b111111;
    tick();
    chk("ill_decode", 8'(bus.state_o), 8'd1);
    chk("ill_pulse", 8'(bus.illegal_op), 8'd1);
    chk("ill_regwrite", 8'(bus.RegWrite), 8'd0);
    chk("ill_memwrite", 8'(bus.MemWrite), 8'd0);
    tick();
    chk("ill_back_fetch", 8'(bus.state_o), 8'd0);
    chk("ill_pulse_end", 8'(bus.illegal_op), 8'd0);

    // Opcode 000101
    bus.Opcode = 6'b000101;
    bus.Zero   = 1'b0;
    tick();
`ifdef MULTICYCLE_MAIN_CONTROL_BNE_EN
    chk("bne_decode_illegal", 8'(bus.illegal_op), 8'd0);
    tick();
    chk("bne_state", 8'(bus.state_o), 8'd12);
    chk("bne_taken_pcen", 8'(bus.PCEn), 8'd1);
    chk("bne_pcsource", 8'(bus.PCSource), 8'd1);
    bus.Zero = 1'b1;
    #1;
    chk("bne_nt_pcen", 8'(bus.PCEn), 8'd0);
    tick();
    chk("bne_back_fetch", 8'(bus.state_o), 8'd0);
`else
    chk("bne_off_illegal", 8'(bus.illegal_op), 8'd1);
    tick();
    chk("bne_off_back_fetch", 8'(bus.state_o), 8'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Moore main-control FSM that sequences the multicycle MIPS datapath: PC/IR, register file, ALU, memory.
- Decodes the 6-bit opcode in DECODE and steps through per-instruction states.
- Drives the datapath muxes and enables, plus the 2-bit AluOp consumed by the ALU-control decoder.
- Adds a memory-ready handshake so fetch, load and store can stall for slow memory.

Parameters:
- OPW, 6, opcode width (fixed by ISA; present for readability).
- STW, 4, state register width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- Opcode  in  6  instruction[31:26] from IR.
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current read/write this cycle.
- IorD  out  1  memory address select: 0=PC, 1=ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  write register select: 0=rt, 1=rd.
- MemtoReg  out  1  write data select: 0=ALUOut, 1=MDR.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A select: 0=PC, 1=A.
- ALUSrcB  out  2  ALU B select: 00=B, 01=4, 10=signext, 11=signext<<2.
- AluOp  out  2  00=add, 01=sub, 10=funct-decoded.
- PCSource  out  2  PC next select: 00=ALU, 01=ALUOut, 10=jump target.
- PCEn  out  1  PC write enable: PCWrite | (branch condition met).
- state_o  out  4  current state (debug).
- instr_done  out  1  one-cycle pulse on the final cycle of every instruction.
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode.

Behaviour:
- Reset:
  - In the cycle after reset is sampled high, state = FETCH(0).
  - While reset is high, every output except state_o is forced to 0.
  - Reset mid-instruction abandons it; no RegWrite or MemWrite occurs in the reset cycle.
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7.
  - BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11, BNE=12 (optional).
  - Codes 13–15 are unreachable; if entered, the next state is FETCH.
- Outputs are pure Moore (functions of state only), except that PCEn, IRWrite and state advance also depend on Zero/mem_ready as stated below.
- FETCH:
  - Outputs: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, AluOp=00, PCSource=00.
  - IRWrite=PCEn=mem_ready.
  - Go to DECODE if mem_ready, else stay (stall; PC and IR unchanged).
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, AluOp=00 (branch target precompute).
  - Next state by opcode: 100011/101011 -> MEMADR; 000000 -> EXEC; 000100 -> BEQ; 001000 -> ADDIEX; 000010 -> JUMP.
  - Any other opcode -> FETCH with illegal_op=1.
- MEMADR: ALUSrcA=1, ALUSrcB=10, AluOp=00. Next state MEMRD if opcode is lw, MEMWR if sw.
- MEMRD: IorD=1, MemRead=1. Go to MEMWB on mem_ready, else stay.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1. Next state FETCH.
- MEMWR: IorD=1, MemWrite=1 (held during stall). On mem_ready: instr_done=1, go to FETCH; else stay.
- EXEC: ALUSrcA=1, ALUSrcB=00, AluOp=10. Next state ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1. Next state FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=00, AluOp=01, PCSource=01, PCEn=Zero, instr_done=1. Next state FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, AluOp=00. Next state ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1. Next state FETCH.
- JUMP: PCSource=10, PCEn=1, instr_done=1. Next state FETCH.
- Outputs not listed for a state are 0.
- Latencies with mem_ready tied high:
  - lw 5 cycles; sw, R-type, addi 4 cycles; beq, j 3 cycles.
  - Each stall cycle adds 1.
- Opcode is sampled only in DECODE and MEMADR; IR is stable there because IRWrite=0.

Optional Feature:
- Macro: MULTICYCLE_MAIN_CONTROL_BNE_EN.
- Defined:
  - Opcode 000101 in DECODE -> BNE.
  - BNE outputs are identical to BEQ except PCEn = ~Zero.
- Undefined:
  - State 12 does not exist.
  - Opcode 000101 is illegal: illegal_op pulse, return to FETCH.

Test Plan:
- Reset mid-EXEC: reset=1 for 1 cycle while state=6 -> RegWrite=0 that cycle, state_o=0 next cycle, all outputs 0 during reset.
- R-type, mem_ready=1, Opcode=000000 -> states 0,1,6,7,0; AluOp=10 in EXEC; RegWrite=1 and RegDst=1 in ALUWB; instr_done pulses once.
- lw with mem_ready low for 2 cycles in FETCH and 3 in MEMRD -> FETCH held 3 cycles with IRWrite=0 until ready; MEMRD held 4 cycles; total 10 cycles; MemtoReg=1 in MEMWB.
- beq, Opcode=000100: Zero=1 -> PCEn=1 and PCSource=01 in state 8; repeat with Zero=0 -> PCEn=0; both return to FETCH.
- Opcode=111111 -> illegal_op=1 in DECODE, next state 0, no RegWrite/MemWrite asserted.
- Opcode=000101: with BNE_EN defined and Zero=0 -> state 12, PCEn=1; without the macro -> illegal_op=1, state 0.
